// File: rtl/spi_arb_pkg.sv
// rtl/spi_arb_pkg.sv - shared defaults and FSM state encoding for the arbitrated SPI master
package spi_arb_pkg;

    localparam int DEFAULT_N       = 8;
    localparam int DEFAULT_CLK_DIV = 4;

    typedef enum logic [7:0] {
        ST_IDLE  = 8'd0,
        ST_SETUP = 8'd1,
        ST_SHIFT = 8'd2,
        ST_HOLD  = 8'd3,
        ST_GAP   = 8'd4
    } state_e;

endpackage

// File: rtl/spi_sync2.sv
// rtl/spi_sync2.sv - two-flop synchronizer for the asynchronous MISO input
module spi_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/spi_arbiter_master.sv
// rtl/spi_arbiter_master.sv - round-robin arbitrated SPI mode-0 master, one N-bit transfer per grant
import spi_arb_pkg::*;

module spi_arbiter_master #(
    parameter int N       = DEFAULT_N,
    parameter int NREQ    = 2,
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*N-1:0]        req_data,
    output logic [NREQ-1:0]          req_ready,
    output logic                     rsp_valid,
    output logic [N-1:0]             rsp_data,
    output logic [$clog2(NREQ)-1:0]  rsp_id,
    output logic                     busy,
    output logic                     SCK,
    output logic                     CS,
    output logic                     MOSI,
    input  logic                     MISO
);

    localparam int IDW = $clog2(NREQ);
    localparam int DW  = $clog2(CLK_DIV);
    localparam int BW  = (N > 1) ? $clog2(N) : 1;
    localparam logic [DW-1:0] DIV_LOAD = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(N - 1);

    state_e          state_q, state_d;
    logic [DW-1:0]   div_q, div_d;
    logic [BW-1:0]   bit_q, bit_d;
    logic [N-1:0]    tx_q, tx_d;
    logic [N-1:0]    rx_q, rx_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic            sck_q, sck_d;
    logic            cs_n_q, cs_n_d;
    logic            mosi_q, mosi_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [N-1:0]    rsp_data_q, rsp_data_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_id;
    logic [IDW-1:0]  cand;
    logic            found;
    logic [N-1:0]    sel_data;
    logic            accept;
    logic            div_zero;
    logic            miso_s;

    spi_sync2 u_miso_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (MISO),
        .q_o   (miso_s)
    );

    // Search begins one past the last winner so every requester gets a turn.
    always_comb begin
        grant    = '0;
        grant_id = '0;
        cand     = '0;
        found    = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            cand = IDW'((int'(ptr_q) + k) % NREQ);
            if (!found && req_valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_id    = cand;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) sel_data = req_data[k*N +: N];
        end
    end

    assign req_ready = (reset && state_q == ST_IDLE) ? grant : '0;
    assign accept    = |req_ready;
    assign div_zero  = (div_q == '0);

    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        bit_d       = bit_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        id_d        = id_q;
        ptr_d       = ptr_q;
        sck_d       = sck_q;
        cs_n_d      = cs_n_q;
        mosi_d      = mosi_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                    div_d   = DIV_LOAD;
                    bit_d   = '0;
                    tx_d    = sel_data;
                    id_d    = grant_id;
                    ptr_d   = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
                    cs_n_d  = 1'b0;
                    mosi_d  = sel_data[N-1];
                end
            end
            ST_SETUP: begin
                if (div_zero) begin
                    state_d = ST_SHIFT;
                    div_d   = DIV_LOAD;
                    sck_d   = 1'b1;
                end else begin
                    div_d = div_q - 1'b1;
                end
            end
            ST_SHIFT: begin
                if (!div_zero) begin
                    div_d = div_q - 1'b1;
                end else begin
                    div_d = DIV_LOAD;
                    if (sck_q) begin
                        // End of high phase: sample, then fall; the last low phase is HOLD.
                        sck_d = 1'b0;
                        rx_d  = {rx_q[N-2:0], miso_s};
                        if (bit_q == LAST_BIT) begin
                            state_d = ST_HOLD;
                        end else begin
                            tx_d   = {tx_q[N-2:0], 1'b0};
                            mosi_d = tx_q[N-2];
                        end
                    end else begin
                        sck_d = 1'b1;
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (!div_zero) begin
                    div_d = div_q - 1'b1;
                end else begin
                    state_d     = ST_GAP;
                    div_d       = DIV_LOAD;
                    cs_n_d      = 1'b1;
                    mosi_d      = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_q;
                    rsp_id_d    = id_q;
                end
            end
            ST_GAP: begin
                if (!div_zero) begin
                    div_d = div_q - 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    div_d   = DIV_LOAD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            id_q        <= '0;
            ptr_q       <= '0;
            sck_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            id_q        <= id_d;
            ptr_q       <= ptr_d;
            sck_q       <= sck_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign SCK       = sck_q;
    assign CS        = cs_n_q;
    assign MOSI      = mosi_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;

endmodule

// File: doc/spi_arbiter_master.md
SPI_ARBITER_MASTER -- requirements
Module: spi_arbiter_master

Interface
REQ-001 SHALL have parameter N, default 8: transfer width in bits.
REQ-002 SHALL have parameter NREQ, default 2: number of requesters.
REQ-003 SHALL have parameter CLK_DIV, default 4: SCK half-period in clk cycles; legal values are 4 or more.
REQ-004 SHALL have port clk, input, 1 bit: system clock; all logic rising-edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port req_valid, input, NREQ bits: per-requester transfer request.
REQ-007 SHALL have port req_data, input, NREQ*N bits: per-requester MOSI byte; requester i occupies bits [i*N +: N].
REQ-008 SHALL have port req_ready, output, NREQ bits: one-hot accept strobe.
REQ-009 SHALL have port rsp_valid, output, 1 bit: one-cycle pulse when a transfer completes.
REQ-010 SHALL have port rsp_data, output, N bits: byte captured from MISO.
REQ-011 SHALL have port rsp_id, output, $clog2(NREQ) bits: index of the requester that owned the transfer.
REQ-012 SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-013 SHALL have port SCK, output, 1 bit: SPI clock, mode 0 (idle low).
REQ-014 SHALL have port CS, output, 1 bit: chip select, active low.
REQ-015 SHALL have port MOSI, output, 1 bit: serial data out, MSB first.
REQ-016 SHALL have port MISO, input, 1 bit: asynchronous serial data in.

Function
REQ-017 SHALL implement FSM states IDLE, SETUP, SHIFT, HOLD and GAP, with an 8-bit enum.
- IDLE->SETUP on acceptance.
- SETUP->SHIFT after CLK_DIV cycles.
- SHIFT->HOLD after the Nth SCK high phase.
- HOLD->GAP after CLK_DIV cycles.
- GAP->IDLE after CLK_DIV cycles.
REQ-018 SHALL assert in IDLE at most one req_ready bit, combinationally, for the round-robin winner among asserted req_valid bits; acceptance = req_valid[i] & req_ready[i].
REQ-019 SHALL apply round-robin priority: search starts at the index after the last-accepted requester and wraps at NREQ-1 -> 0; after reset the search starts at 0.
REQ-020 SHALL latch req_data[i] and id i in the acceptance cycle; later changes to req_data SHALL be ignored.
REQ-021 SHALL keep req_ready all-zero outside IDLE; a requester MAY drop req_valid before acceptance without side effects.
REQ-022 SHALL drive CS low and MOSI = bit N-1 in the cycle after acceptance (SETUP entry), with SCK low.
REQ-023 SHALL run each SHIFT bit as SCK high for CLK_DIV cycles then low for CLK_DIV cycles; the final low phase is the HOLD state.
REQ-024 SHALL update MOSI to the next lower bit on each SCK falling edge, except after the last bit.
REQ-025 SHALL pass MISO through a 2-flop synchronizer and shift the synchronized value, MSB first, into the receive register on the last clk cycle of each SCK high phase.
REQ-026 SHALL hold CS low for exactly CLK_DIV*(2N+1) cycles per transfer (68 cycles at N=8, CLK_DIV=4).
REQ-027 SHALL, on GAP entry, drive CS high and MOSI 0, pulse rsp_valid for one cycle, and hold rsp_data/rsp_id stable until the next rsp_valid.
REQ-028 SHALL keep CS high for at least CLK_DIV+1 cycles between consecutive transfers, including back-to-back requests.
REQ-029 SHALL use a bit counter with range 0..N-1 that never wraps.
REQ-030 SHALL use a divider counter that reloads to CLK_DIV-1 at every phase boundary.

Reset
REQ-031 SHALL, on assertion of reset and regardless of clk: SCK=0, CS=1, MOSI=0, req_ready=0, rsp_valid=0, rsp_data=0, rsp_id=0, busy=0, state=IDLE, round-robin pointer = requester 0 first.
REQ-032 SHALL drop any in-flight transfer on reset with no rsp_valid pulse; the first acceptance SHALL occur no earlier than the first clk edge after reset release.

Structure
REQ-033 SHALL place the state enum, default N and default CLK_DIV in shared package spi_arb_pkg.
REQ-034 SHALL instantiate sub-module spi_sync2 (parameterless 2-flop synchronizer, reset value 0) for MISO.
REQ-035 SHALL keep arbitration, FSM and shift datapath inside spi_arbiter_master.

Verification
REQ-036 SHALL cover a single request: req0 0xA5 with a mode-0 slave model returning 0x0A -> MOSI at SCK rising edges = 1,0,1,0,0,1,0,1; rsp_data=0x0A, rsp_id=0; CS low for 68 cycles.
REQ-037 SHALL cover simultaneous requests: req0=0x11, req1=0x22 asserted in the same cycle, both held -> req0 served first, then req1; CS high for 5 or more cycles between the two transfers.
REQ-038 SHALL cover fairness: both requesters continuously valid for 4 transfers -> rsp_id sequence 0,1,0,1.
REQ-039 SHALL cover reset mid-transfer: reset asserted during bit 3 -> SCK=0, CS=1 in the same cycle; no rsp_valid; the next request after release is requester 0 and completes correctly.
REQ-040 SHALL cover request withdrawal: req1 valid for 1 cycle while busy, then dropped -> no transfer for req1 and req_ready[1] never asserted.
REQ-041 SHALL cover MISO all ones: MISO tied to 1 -> rsp_data=0xFF.
REQ-042 SHALL cover CLK_DIV=8: CS low for 136 cycles, with SCK high and low phases of 8 cycles each.
